machine_switcher: RTL and testbench
===================================

Name: machine_switcher

Overview:
- Parametrised selector between NUM_MACHINES microcomputer cores that share one video output, one SD-SPI port and one drive LED.
- Replaces the bare combinational output mux and the per-core clock gating with a sequenced switch: hold all cores in reset, release only the target core, blank video until that core's first clean frame, then pass its signals through.
- Sits between the core instances and the video cleaner / SD pins in emu.

Parameters:
- NUM_MACHINES, 4, number of attached cores (2..16).
- SEL_W, 2, width of selection code; must satisfy 2**SEL_W >= NUM_MACHINES.
- RGB_W, 2, bits per colour per core.
- RESET_HOLD, 1024, cycles all cores are held in reset on a switch or user reset (>=2).
- SYNC_TIMEOUT, 2000000, maximum cycles to wait for the new core's first frame.

Ports:
- clk  in  1  system clock, which is also the core clock.
- N_RESET  in  1  asynchronous active-low reset.
- sel_req  in  SEL_W  requested core index, from OSD status.
- user_reset  in  1  level reset request from OSD or button.
- m_r, m_g, m_b  in  NUM_MACHINES*RGB_W each  per-core colour; core i occupies bits [i*RGB_W +: RGB_W].
- m_hs, m_vs, m_hblank, m_vblank, m_cepix  in  NUM_MACHINES each  per-core sync, blanking and pixel enable.
- m_sd_cs, m_sd_mosi, m_sd_sck, m_led  in  NUM_MACHINES each  per-core SD-SPI outputs and drive LED.
- machine_en  out  NUM_MACHINES  one-hot clock enable to the cores.
- machine_n_reset  out  NUM_MACHINES  per-core active-low reset.
- r, g, b  out  RGB_W each  selected colour.
- hs, vs, hblank, vblank, ce_pix  out  1 each  selected sync, blanking and pixel enable.
- sd_cs, sd_mosi, sd_sck, drive_led  out  1 each  selected SD-SPI signals and LED.
- active_sel  out  SEL_W  index of the core currently running.
- busy  out  1  high whenever the state is not RUN.
- sync_timeout  out  1  sticky flag, set when SYNC ended by timeout.

Behaviour:
- States: HOLD, SYNC, RUN. Registers: target (SEL_W), cnt (sized by $clog2 of the larger of RESET_HOLD and SYNC_TIMEOUT).
- Reset values:
  - state=HOLD, target=0, cnt=0, active_sel=0, sync_timeout=0.
  - machine_en=1 at bit 0 only, machine_n_reset=all 0.
  - r/g/b=0, hs=0, vs=0, hblank=1, vblank=1, ce_pix=0.
  - sd_cs=1, sd_mosi=1, sd_sck=0, drive_led=0, busy=1.
- Valid request: sel_req < NUM_MACHINES and sel_req != target. Out-of-range codes are ignored and target is unchanged.
- A valid request in any state → HOLD: target<=sel_req, cnt<=0. This also applies mid-HOLD and mid-SYNC, which restarts the hold count.
- user_reset high in any state → HOLD with the same target, cnt<=0, held while user_reset is high.
- If a valid request and user_reset arrive together, the request wins: the new target is loaded and the count restarts.
- HOLD:
  - All machine_n_reset bits are 0. machine_en is one-hot of target, so the target core clocks its synchronous resets.
  - cnt increments each cycle.
  - At cnt==RESET_HOLD-1, go to SYNC with cnt<=0.
- SYNC:
  - machine_n_reset[target]=1; all other bits stay 0.
  - Leave for RUN on the first cycle where m_cepix[target]=1 and m_vblank[target] falls 1→0. The edge detector is reset on SYNC entry, so a stale level cannot trigger it.
  - If cnt reaches SYNC_TIMEOUT-1 first, go to RUN and set sync_timeout=1.
  - sync_timeout clears only on N_RESET or on the next successful SYNC exit.
- RUN:
  - active_sel=target.
  - The output mux passes core target through with exactly 1 cycle of registered latency. All video, SD and LED outputs share this latency, so ce_pix stays aligned with the data.
- Outside RUN, all outputs are forced to their reset values, except machine_en and machine_n_reset as described above.
- busy is 1 in HOLD and SYNC, 0 in RUN. It is registered together with the state.
- Non-selected cores always have machine_en=0 and machine_n_reset=0.
- No combinational path exists from any m_* input to any output.

Test Plan:
- Release N_RESET with sel_req=0 and core 0 producing a frame → machine_n_reset stays 0000 for 1024 cycles, then becomes 0001. VGA outputs stay blanked until core 0's first vblank 1→0 with cepix, then follow its inputs 1 cycle later. busy falls at that point.
- In RUN on core 0, set sel_req=2 → next cycle machine_en=0100, machine_n_reset=0000, busy=1, sd_cs=1. After 1024 cycles machine_n_reset=0100. active_sel=2 after core 2's first vblank fall.
- During HOLD at cnt=500 toward core 2, set sel_req=3 → the count restarts. machine_n_reset=1000 exactly 1024 cycles after the change, and core 2 is never released.
- Set sel_req=3 with NUM_MACHINES=3 → no state change, target stays unchanged, and busy stays 0.
- Target core never de-asserts vblank, with SYNC_TIMEOUT=100 for the test → RUN entered 100 cycles after SYNC entry and sync_timeout=1. A later successful switch clears the flag.
- Pulse user_reset for 10 cycles in RUN → HOLD for 10+1024 cycles with the same target, then SYNC, and outputs blanked throughout. Assert N_RESET low mid-SYNC → all outputs return to their reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/machine_switcher.sv
// Sequenced selector between several microcomputer cores that share one video
// output, one SD-SPI port and one drive LED: hold in reset, release, sync, run.
module machine_switcher #(
  parameter int NUM_MACHINES = 4,
  parameter int SEL_W        = 2,
  parameter int RGB_W        = 2,
  parameter int RESET_HOLD   = 1024,
  parameter int SYNC_TIMEOUT = 2000000
) (
  input  logic                      clk,
  input  logic                      N_RESET,
  input  logic [SEL_W-1:0]          sel_req,
  input  logic                      user_reset,
  input  logic [NUM_MACHINES*RGB_W-1:0] m_r,
  input  logic [NUM_MACHINES*RGB_W-1:0] m_g,
  input  logic [NUM_MACHINES*RGB_W-1:0] m_b,
  input  logic [NUM_MACHINES-1:0]   m_hs,
  input  logic [NUM_MACHINES-1:0]   m_vs,
  input  logic [NUM_MACHINES-1:0]   m_hblank,
  input  logic [NUM_MACHINES-1:0]   m_vblank,
  input  logic [NUM_MACHINES-1:0]   m_cepix,
  input  logic [NUM_MACHINES-1:0]   m_sd_cs,
  input  logic [NUM_MACHINES-1:0]   m_sd_mosi,
  input  logic [NUM_MACHINES-1:0]   m_sd_sck,
  input  logic [NUM_MACHINES-1:0]   m_led,
  output logic [NUM_MACHINES-1:0]   machine_en,
  output logic [NUM_MACHINES-1:0]   machine_n_reset,
  output logic [RGB_W-1:0]          r,
  output logic [RGB_W-1:0]          g,
  output logic [RGB_W-1:0]          b,
  output logic                      hs,
  output logic                      vs,
  output logic                      hblank,
  output logic                      vblank,
  output logic                      ce_pix,
  output logic                      sd_cs,
  output logic                      sd_mosi,
  output logic                      sd_sck,
  output logic                      drive_led,
  output logic [SEL_W-1:0]          active_sel,
  output logic                      busy,
  output logic                      sync_timeout
);

  localparam int CNT_MAX = (RESET_HOLD > SYNC_TIMEOUT) ? RESET_HOLD : SYNC_TIMEOUT;
  localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    SYNC = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t               state, nxt_state;
  logic [SEL_W-1:0]     target, nxt_target;
  logic [CNT_W-1:0]     cnt, nxt_cnt;
  logic                 vblank_prev, nxt_prev;
  logic                 nxt_timeout;
  logic                 req_valid;
  logic                 vb_fall;
  logic [NUM_MACHINES-1:0] tgt_onehot;

  logic [RGB_W-1:0]     sel_r, sel_g, sel_b;
  logic                 sel_hs, sel_vs, sel_hblank, sel_vblank, sel_cepix;
  logic                 sel_sd_cs, sel_sd_mosi, sel_sd_sck, sel_led;

  // Out-of-range codes and re-selecting the current core are both ignored.
  assign req_valid  = (int'(sel_req) < NUM_MACHINES) && (sel_req != target);
  assign nxt_target = req_valid ? sel_req : target;

  // Source mux keyed on the core that will own the outputs after this edge.
  always_comb begin
    // NOTE: every signal gets a default before the loop so no latch is inferred.
    tgt_onehot  = '0;
    sel_r       = '0;
    sel_g       = '0;
    sel_b       = '0;
    sel_hs      = 1'b0;
    sel_vs      = 1'b0;
    sel_hblank  = 1'b1;
    sel_vblank  = 1'b1;
    sel_cepix   = 1'b0;
    sel_sd_cs   = 1'b1;
    sel_sd_mosi = 1'b1;
    sel_sd_sck  = 1'b0;
    sel_led     = 1'b0;
    for (int i = 0; i < NUM_MACHINES; i++) begin
      if (nxt_target == SEL_W'(i)) begin
        tgt_onehot[i] = 1'b1;
        sel_r         = m_r[i*RGB_W +: RGB_W];
        sel_g         = m_g[i*RGB_W +: RGB_W];
        sel_b         = m_b[i*RGB_W +: RGB_W];
        sel_hs        = m_hs[i];
        sel_vs        = m_vs[i];
        sel_hblank    = m_hblank[i];
        sel_vblank    = m_vblank[i];
        sel_cepix     = m_cepix[i];
        sel_sd_cs     = m_sd_cs[i];
        sel_sd_mosi   = m_sd_mosi[i];
        sel_sd_sck    = m_sd_sck[i];
        sel_led       = m_led[i];
      end
    end
  end

  // First clean frame: vblank falls on a pixel-enable cycle.
  assign vb_fall = vblank_prev & ~sel_vblank & sel_cepix;

  always_comb begin
    nxt_state   = state;
    nxt_cnt     = cnt + CNT_W'(1);
    nxt_timeout = sync_timeout;
    nxt_prev    = sel_vblank;
    if (req_valid || user_reset) begin
      nxt_state = HOLD;
      nxt_cnt   = '0;
    end else begin
      case (state)
        HOLD: begin
          if (cnt == CNT_W'(RESET_HOLD - 1)) begin
            nxt_state = SYNC;
            nxt_cnt   = '0;
            nxt_prev  = 1'b0;  // a level held over from before release must not count
          end
        end
        SYNC: begin
          if (vb_fall) begin
            nxt_state   = RUN;
            nxt_cnt     = '0;
            nxt_timeout = 1'b0;
          end else if (cnt == CNT_W'(SYNC_TIMEOUT - 1)) begin
            nxt_state   = RUN;
            nxt_cnt     = '0;
            nxt_timeout = 1'b1;
          end
        end
        RUN: begin
          nxt_cnt = cnt;
        end
        default: begin
          nxt_state = HOLD;
          nxt_cnt   = '0;
        end
      endcase
    end
  end

  // All outputs are registered from the next state, giving one cycle of latency.
  always_ff @(posedge clk or negedge N_RESET) begin
    if (!N_RESET) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples pre-edge values regardless of statement order.
      state           <= HOLD;
      target          <= '0;
      cnt             <= '0;
      vblank_prev     <= 1'b0;
      sync_timeout    <= 1'b0;
      busy            <= 1'b1;
      active_sel      <= '0;
      machine_en      <= NUM_MACHINES'(1);
      machine_n_reset <= '0;
      r               <= '0;
      g               <= '0;
      b               <= '0;
      hs              <= 1'b0;
      vs              <= 1'b0;
      hblank          <= 1'b1;
      vblank          <= 1'b1;
      ce_pix          <= 1'b0;
      sd_cs           <= 1'b1;
      sd_mosi         <= 1'b1;
      sd_sck          <= 1'b0;
      drive_led       <= 1'b0;
    end else begin
      state           <= nxt_state;
      target          <= nxt_target;
      cnt             <= nxt_cnt;
      vblank_prev     <= nxt_prev;
      sync_timeout    <= nxt_timeout;
      busy            <= (nxt_state != RUN);
      machine_en      <= tgt_onehot;
      machine_n_reset <= (nxt_state == SYNC) ? tgt_onehot : '0;
      if (nxt_state == RUN) begin
        active_sel <= nxt_target;
        r          <= sel_r;
        g          <= sel_g;
        b          <= sel_b;
        hs         <= sel_hs;
        vs         <= sel_vs;
        hblank     <= sel_hblank;
        vblank     <= sel_vblank;
        ce_pix     <= sel_cepix;
        sd_cs      <= sel_sd_cs;
        sd_mosi    <= sel_sd_mosi;
        sd_sck     <= sel_sd_sck;
        drive_led  <= sel_led;
      end else begin
        active_sel <= '0;
        r          <= '0;
        g          <= '0;
        b          <= '0;
        hs         <= 1'b0;
        vs         <= 1'b0;
        hblank     <= 1'b1;
        vblank     <= 1'b1;
        ce_pix     <= 1'b0;
        sd_cs      <= 1'b1;
        sd_mosi    <= 1'b1;
        sd_sck     <= 1'b0;
        drive_led  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_machine_switcher.sv
// Randomised bench for machine_switcher: a behavioural model predicts every
// cycle's outputs into a queue that an independent monitor drains and compares.
module tb_machine_switcher;

  localparam int N  = 3;
  localparam int SW = 2;
  localparam int RW = 2;
  localparam int RH = 64;
  localparam int ST = 100;
  localparam int CW = N * RW;

  logic clk = 1'b0;
  logic N_RESET;
  logic [SW-1:0] sel_req;
  logic user_reset;
  logic [CW-1:0] m_r, m_g, m_b;
  logic [N-1:0] m_hs, m_vs, m_hblank, m_vblank, m_cepix;
  logic [N-1:0] m_sd_cs, m_sd_mosi, m_sd_sck, m_led;
  logic [N-1:0] machine_en, machine_n_reset;
  logic [RW-1:0] r, g, b;
  logic hs, vs, hblank, vblank, ce_pix, sd_cs, sd_mosi, sd_sck, drive_led;
  logic [SW-1:0] active_sel;
  logic busy, sync_timeout;

  machine_switcher #(
    .NUM_MACHINES(N), .SEL_W(SW), .RGB_W(RW), .RESET_HOLD(RH), .SYNC_TIMEOUT(ST)
  ) dut (
    .clk(clk), .N_RESET(N_RESET), .sel_req(sel_req), .user_reset(user_reset),
    .m_r(m_r), .m_g(m_g), .m_b(m_b), .m_hs(m_hs), .m_vs(m_vs),
    .m_hblank(m_hblank), .m_vblank(m_vblank), .m_cepix(m_cepix),
    .m_sd_cs(m_sd_cs), .m_sd_mosi(m_sd_mosi), .m_sd_sck(m_sd_sck), .m_led(m_led),
    .machine_en(machine_en), .machine_n_reset(machine_n_reset),
    .r(r), .g(g), .b(b), .hs(hs), .vs(vs), .hblank(hblank), .vblank(vblank),
    .ce_pix(ce_pix), .sd_cs(sd_cs), .sd_mosi(sd_mosi), .sd_sck(sd_sck),
    .drive_led(drive_led), .active_sel(active_sel), .busy(busy),
    .sync_timeout(sync_timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0]  en;
    logic [N-1:0]  nrst;
    logic [RW-1:0] r, g, b;
    logic hs, vs, hblank, vblank, ce_pix, sd_cs, sd_mosi, sd_sck, led;
    logic [SW-1:0] asel;
    logic busy, tout;
  } obs_t;

  obs_t exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  // Driver-side controls, applied to the DUT only just after a falling edge.
  logic [SW-1:0] drv_sel = '0;
  logic drv_ureset = 1'b0;
  logic drv_rst_n  = 1'b0;
  logic [N-1:0] stuck = '0;
  logic [N-1:0] vb_lvl = '0;

  // Reference model: hold/sync countdowns and a running flag.
  int md_tgt, md_hold_left, md_sync_left;
  bit md_running, md_prev, md_tflag;

  task automatic check(input string name, input obs_t act, input obs_t exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
  endtask

  function automatic obs_t reset_obs();
    obs_t o;
    o = '0;
    o.en = '0;
    o.en[0] = 1'b1;
    o.hblank = 1'b1;
    o.vblank = 1'b1;
    o.sd_cs = 1'b1;
    o.sd_mosi = 1'b1;
    o.busy = 1'b1;
    return o;
  endfunction

  function automatic obs_t dut_obs();
    obs_t o;
    o.en = machine_en;  o.nrst = machine_n_reset;
    o.r = r;  o.g = g;  o.b = b;
    o.hs = hs;  o.vs = vs;  o.hblank = hblank;  o.vblank = vblank;
    o.ce_pix = ce_pix;  o.sd_cs = sd_cs;  o.sd_mosi = sd_mosi;
    o.sd_sck = sd_sck;  o.led = drive_led;
    o.asel = active_sel;  o.busy = busy;  o.tout = sync_timeout;
    return o;
  endfunction

  task automatic drive_cores();
    for (int i = 0; i < N; i++) begin
      m_cepix[i] = 1'($urandom_range(0, 1));
      if (stuck[i]) vb_lvl[i] = 1'b1;
      else if (m_cepix[i] && $urandom_range(0, 11) == 0) vb_lvl[i] = ~vb_lvl[i];
    end
    m_vblank  = vb_lvl;
    m_r = CW'($urandom);  m_g = CW'($urandom);  m_b = CW'($urandom);
    m_hs = N'($urandom);  m_vs = N'($urandom);  m_hblank = N'($urandom);
    m_sd_cs = N'($urandom);  m_sd_mosi = N'($urandom);
    m_sd_sck = N'($urandom);  m_led = N'($urandom);
  endtask

  // Advance the model by one rising edge using the inputs now on the pins.
  task automatic model_step(output obs_t e);
    bit fall;
    if (!N_RESET) begin
      md_tgt = 0;  md_hold_left = RH;  md_running = 0;  md_tflag = 0;  md_prev = 0;
    end else if ((int'(sel_req) < N && int'(sel_req) != md_tgt) || user_reset) begin
      if (int'(sel_req) < N) md_tgt = int'(sel_req);
      md_hold_left = RH;
      md_running = 0;
    end else if (md_hold_left > 0) begin
      md_hold_left--;
      if (md_hold_left == 0) begin
        md_sync_left = ST;
        md_prev = 0;
      end
    end else if (!md_running) begin
      md_sync_left--;
      fall = md_prev && !m_vblank[md_tgt] && m_cepix[md_tgt];
      md_prev = m_vblank[md_tgt];
      if (fall) begin
        md_running = 1;  md_tflag = 0;
      end else if (md_sync_left == 0) begin
        md_running = 1;  md_tflag = 1;
      end
    end
    e = reset_obs();
    e.en = '0;
    e.en[md_tgt] = 1'b1;
    if (md_hold_left == 0 && !md_running) e.nrst[md_tgt] = 1'b1;
    if (md_running) begin
      e.r = m_r[md_tgt*RW +: RW];  e.g = m_g[md_tgt*RW +: RW];  e.b = m_b[md_tgt*RW +: RW];
      e.hs = m_hs[md_tgt];  e.vs = m_vs[md_tgt];
      e.hblank = m_hblank[md_tgt];  e.vblank = m_vblank[md_tgt];
      e.ce_pix = m_cepix[md_tgt];  e.sd_cs = m_sd_cs[md_tgt];
      e.sd_mosi = m_sd_mosi[md_tgt];  e.sd_sck = m_sd_sck[md_tgt];
      e.led = m_led[md_tgt];
      e.asel = SW'(md_tgt);
      e.busy = 1'b0;
    end
    e.tout = md_tflag;
  endtask

  task automatic cycle();
    obs_t e;
    @(negedge clk);
    if (N_RESET && !drv_rst_n) begin
      N_RESET = 1'b0;
      #1 check("async_reset", dut_obs(), reset_obs());
    end else begin
      N_RESET = drv_rst_n;
    end
    sel_req = drv_sel;
    user_reset = drv_ureset;
    drive_cores();
    model_step(e);
    exp_q.push_back(e);
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  // Monitor: one comparison per rising edge, decoupled from the driver.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL queue_underflow at %0t: got empty queue expected an entry", $time);
      end else begin
        check("outputs", dut_obs(), exp_q.pop_front());
      end
    end
  end

  initial begin
    obs_t e;
    int budget;
    N_RESET = 1'b1;
    sel_req = '0;
    user_reset = 1'b0;
    drive_cores();
    #1 N_RESET = 1'b0;
    model_step(e);
    exp_q.push_back(e);
    #1 check("reset_state", dut_obs(), reset_obs());

    // Power-up on core 0.
    drv_rst_n = 1'b1;
    run(RH + ST + 20);

    // Switch to core 2, then redirect to core 1 part-way through the hold.
    drv_sel = 2'd2;
    run(30);
    drv_sel = 2'd1;
    run(RH + ST + 20);

    // Code 3 is out of range with three cores.
    drv_sel = 2'd3;
    run(50);

    // Core 2 never leaves vblank: sync must time out; a later switch clears it.
    stuck = 3'b100;
    drv_sel = 2'd2;
    run(RH + ST + 10);
    stuck = '0;
    drv_sel = 2'd0;
    run(RH + ST + 40);

    // User reset pulse, then a request arriving together with user reset.
    drv_ureset = 1'b1;
    run(10);
    drv_ureset = 1'b0;
    run(RH + ST + 20);
    drv_sel = 2'd1;
    drv_ureset = 1'b1;
    run(3);
    drv_ureset = 1'b0;
    run(RH + ST + 20);

    // Random mix of requests, user resets and dead cores.
    repeat (40) begin
      case ($urandom_range(0, 5))
        0, 1, 2: drv_sel = SW'($urandom_range(0, 3));
        3: begin
          drv_ureset = 1'b1;
          run($urandom_range(1, 5));
          drv_ureset = 1'b0;
        end
        4: stuck = N'($urandom);
        default: ;
      endcase
      run($urandom_range(1, RH + ST));
    end

    // Asynchronous reset in the middle of SYNC.
    stuck = '1;
    drv_sel = (drv_sel == 2'd1) ? 2'd2 : 2'd1;
    budget = 0;
    cycle();
    while (!(md_hold_left == 0 && !md_running) && budget < 500) begin
      cycle();
      budget++;
    end
    n_checks++;
    if (md_hold_left == 0 && !md_running) n_pass++;
    else $display("FAIL reach_sync: got no sync phase within %0d cycles expected sync", budget);
    run(20);
    drv_rst_n = 1'b0;
    cycle();
    run(3);
    drv_rst_n = 1'b1;
    stuck = '0;
    run(RH + ST + 40);

    @(posedge clk);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
